// File: rtl/shader_rr_arb_pkg.sv
// Shared raytracer types for the shader arbiter slice: the payload record
// handed to the shader cores and the number of shader request sources.
package shader_rr_arb_pkg;

   localparam int SHADER_NUM_SRC = 4;

   typedef struct packed {
      logic [7:0]  ray_id;
      logic [15:0] prim_id;
      logic        hit;
      logic [6:0]  shader_id;
   } to_shader_t;

endpackage

// File: rtl/shader_rr_arb_rr_pick.sv
// Rotating first-one search: finds the first asserted request at or after
// last+1, wrapping at N. Purely combinational.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int IW = $clog2(N);

   // walk the N candidate positions in priority order, keep the first hit
   always_comb begin
      logic [IW:0] j;
      j     = '0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned off = 1; off <= N; off++) begin
         j = {1'b0, last} + (IW+1)'(off);
         if (j >= (IW+1)'(N)) begin
            j = j - (IW+1)'(N);
         end
         if (!any && req[j[IW-1:0]]) begin
            any               = 1'b1;
            grant[j[IW-1:0]]  = 1'b1;
            idx               = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/shader_rr_arb.sv
// Round-robin arbiter feeding a single registered output entry toward the
// shader cores. Optional statistics (per-requester grant counters and the
// longest stall seen) are built when SHADER_ARB_STATS_EN is defined.
module shader_rr_arb
   import shader_rr_arb_pkg::*;
#(
   parameter int NUM_IN = SHADER_NUM_SRC,
   parameter int WIDTH  = $bits(to_shader_t)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_IN-1:0]              valid_us,
   input  logic [NUM_IN-1:0][WIDTH-1:0]   data_us,
   output logic [NUM_IN-1:0]              stall_us,
   input  logic                           pause,
   output logic                           valid_ds,
   output logic [WIDTH-1:0]               data_ds,
   output logic [$clog2(NUM_IN)-1:0]      src_ds,
   input  logic                           stall_ds
`ifdef SHADER_ARB_STATS_EN
   ,
   output logic [NUM_IN-1:0][15:0]        grant_cnt,
   output logic [15:0]                    max_wait
`endif
);

   localparam int IW = $clog2(NUM_IN);

   logic              drain;
   logic              open;
   logic              pick_en;
   logic [NUM_IN-1:0] req;
   logic [NUM_IN-1:0] grant;
   logic [IW-1:0]     pick_idx;
   logic              grant_any;
   logic [IW-1:0]     last_grant;

   // The output slot accepts a new item when empty or draining this cycle;
   // reset also suppresses grants so every stall_us mirrors valid_us.
   assign drain   = valid_ds & ~stall_ds;
   assign open    = ~valid_ds | drain;
   assign pick_en = open & ~pause & ~rst;
   assign req     = valid_us & {NUM_IN{pick_en}};

   rr_pick #(
      .N (NUM_IN)
   ) u_pick (
      .req   (req),
      .last  (last_grant),
      .grant (grant),
      .idx   (pick_idx),
      .any   (grant_any)
   );

   assign stall_us = valid_us & ~grant;

   // output register and round-robin pointer; pointer moves only on a grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_ds   <= 1'b0;
         data_ds    <= '0;
         src_ds     <= '0;
         last_grant <= IW'(NUM_IN - 1);
      end else begin
         valid_ds <= grant_any | (valid_ds & stall_ds);
         if (grant_any) begin
            data_ds    <= data_us[pick_idx];
            src_ds     <= pick_idx;
            last_grant <= pick_idx;
         end
      end
   end

`ifdef SHADER_ARB_STATS_EN
   logic [NUM_IN-1:0][15:0] wait_cnt;
   logic [NUM_IN-1:0][15:0] wait_nxt;
   logic [15:0]             max_nxt;

   // per-requester run length of valid-and-stalled cycles, and the new maximum
   always_comb begin
      wait_nxt = '0;
      max_nxt  = max_wait;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (stall_us[i]) begin
            wait_nxt[i] = (wait_cnt[i] == '1) ? wait_cnt[i] : 16'(wait_cnt[i] + 16'd1);
         end
         if (wait_nxt[i] > max_nxt) begin
            max_nxt = wait_nxt[i];
         end
      end
   end

   // saturating grant counters and wait tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
         wait_cnt  <= '0;
         max_wait  <= '0;
      end else begin
         wait_cnt <= wait_nxt;
         max_wait <= max_nxt;
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i] && grant_cnt[i] != '1) begin
               grant_cnt[i] <= 16'(grant_cnt[i] + 16'd1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_shader_rr_arb.sv
// Self-checking bench for shader_rr_arb: directed vector table, hand-written
// reset sequence, and randomized traffic against a behavioural model.
module tb_shader_rr_arb;
   import shader_rr_arb_pkg::*;

   localparam int N = 4;
   localparam int W = $bits(to_shader_t);

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        valid_us;
   logic [N-1:0][W-1:0] data_us;
   logic [N-1:0]        stall_us;
   logic                pause;
   logic                valid_ds;
   logic [W-1:0]        data_ds;
   logic [1:0]          src_ds;
   logic                stall_ds;
`ifdef SHADER_ARB_STATS_EN
   logic [N-1:0][15:0]  grant_cnt;
   logic [15:0]         max_wait;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_src;
   int           m_last;
   logic [N-1:0] pre_stall;

   shader_rr_arb #(
      .NUM_IN (N),
      .WIDTH  (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_us (valid_us),
      .data_us  (data_us),
      .stall_us (stall_us),
      .pause    (pause),
      .valid_ds (valid_ds),
      .data_ds  (data_ds),
      .src_ds   (src_ds),
      .stall_ds (stall_ds)
`ifdef SHADER_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .max_wait  (max_wait)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = N - 1;
   endtask

   // who should win this cycle: -1 when the slot is busy, paused, or nobody asks
   function automatic int model_pick();
      int g;
      g = -1;
      if ((!m_valid || !stall_ds) && !pause) begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && valid_us[(m_last + k) % N]) g = (m_last + k) % N;
         end
      end
      return g;
   endfunction

   // one clock: inputs already applied at posedge+1; checks stall before the
   // edge and the output register after it
   task automatic do_cycle(input string tag);
      int g;
      logic [N-1:0] exp_stall;
      g = model_pick();
      exp_stall = valid_us;
      if (g >= 0) exp_stall[g] = 1'b0;
      #2;
      pre_stall = stall_us;
      check({tag, ".stall_us"}, 64'(stall_us), 64'(exp_stall));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = data_us[g];
         m_src   = g;
         m_last  = g;
      end else if (m_valid && !stall_ds) begin
         m_valid = 1'b0;
      end
      check({tag, ".valid_ds"}, 64'(valid_ds), 64'(m_valid));
      check({tag, ".src_ds"},   64'(src_ds),   64'(m_src));
      check({tag, ".data_ds"},  64'(data_ds),  64'(m_data));
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic         pause;
      logic         stall;
      logic [N-1:0] exp_stall;
      logic         exp_valid;
      logic [1:0]   exp_src;
   } vec_t;

   vec_t vq[$];

   initial begin
      logic [W-1:0] base;
`ifdef SHADER_ARB_STATS_EN
      logic [N-1:0][15:0] saved_cnt;
`endif
      base = W'(32'hC0DE0000);

      // directed table: rotation, single requester, held item, pause
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'hE, 1'b1, 2'd0});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'hD, 1'b1, 2'd1});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'hB, 1'b1, 2'd2});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'h7, 1'b1, 2'd3});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'hE, 1'b1, 2'd0});
      for (int i = 0; i < 5; i++) vq.push_back('{4'h4, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2});
      for (int i = 0; i < 3; i++) vq.push_back('{4'hF, 1'b0, 1'b1, 4'hF, 1'b1, 2'd2});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'h7, 1'b1, 2'd3});
      vq.push_back('{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 2'd3});
      vq.push_back('{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 2'd3});
      vq.push_back('{4'hF, 1'b0, 1'b0, 4'hE, 1'b1, 2'd0});

      // reset state
      rst      = 1'b1;
      valid_us = 4'hA;
      pause    = 1'b0;
      stall_ds = 1'b0;
      for (int i = 0; i < N; i++) data_us[i] = base + W'(i);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst.valid_ds", 64'(valid_ds), 64'd0);
      check("rst.data_ds",  64'(data_ds),  64'd0);
      check("rst.src_ds",   64'(src_ds),   64'd0);
      check("rst.stall_us", 64'(stall_us), 64'hA);
      rst = 1'b0;

      foreach (vq[i]) begin
         valid_us = vq[i].valid;
         pause    = vq[i].pause;
         stall_ds = vq[i].stall;
         do_cycle($sformatf("vec%0d", i));
         check($sformatf("vec%0d.tbl_stall", i), 64'(pre_stall), 64'(vq[i].exp_stall));
         check($sformatf("vec%0d.tbl_valid", i), 64'(valid_ds),  64'(vq[i].exp_valid));
         if (vq[i].exp_valid) begin
            check($sformatf("vec%0d.tbl_src", i),  64'(src_ds),  64'(vq[i].exp_src));
            check($sformatf("vec%0d.tbl_data", i), 64'(data_ds), 64'(base + W'(vq[i].exp_src)));
         end
      end

      // reset while an item is held under downstream stall
      valid_us = 4'hF;
      stall_ds = 1'b1;
      do_cycle("hold");
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst.valid_ds", 64'(valid_ds), 64'd0);
      check("midrst.stall_us", 64'(stall_us), 64'hF);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      valid_us = 4'h6;
      stall_ds = 1'b0;
      do_cycle("postrst");
      check("postrst.src", 64'(src_ds), 64'd1);

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         valid_us = 4'($urandom_range(0, 15));
         pause    = ($urandom_range(0, 7) == 0);
         stall_ds = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++) data_us[i] = W'($urandom);
         do_cycle($sformatf("rnd%0d", c));
      end

`ifdef SHADER_ARB_STATS_EN
      // saturation of a single grant counter
      pause    = 1'b0;
      stall_ds = 1'b0;
      valid_us = 4'h0;
      @(posedge clk);
      #1;
      saved_cnt = grant_cnt;
      valid_us  = 4'h2;
      repeat (70000) @(posedge clk);
      #1;
      valid_us = 4'h0;
      check("stats.cnt1", 64'(grant_cnt[1]), 64'hFFFF);
      check("stats.cnt0", 64'(grant_cnt[0]), 64'(saved_cnt[0]));
      check("stats.cnt2", 64'(grant_cnt[2]), 64'(saved_cnt[2]));
      check("stats.cnt3", 64'(grant_cnt[3]), 64'(saved_cnt[3]));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
